input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner_pkg.sv | 19 +
 rtl/debounce.sv | 37 +++
 rtl/input_conditioner.sv | 55 +++++
 tb/tb_input_conditioner.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: shared button indices, sizes and debounce default used with the PIA
package input_conditioner_pkg;
  localparam int unsigned DEBOUNCE_BITS_DEFAULT = 16;
  localparam int unsigned NUM_BTN = 7;
  localparam int unsigned NUM_SW = 4;
  typedef enum int unsigned {
    BTN_RESET  = 0,
    BTN_FIRE   = 1,
    BTN_SELECT = 2,
    BTN_UP     = 3,
    BTN_DOWN   = 4,
    BTN_LEFT   = 5,
    BTN_RIGHT  = 6
  } btn_idx_e;
  // Active-low levels for an opposing direction pair; both pressed reads as neither pressed
  function automatic logic [1:0] socd_pair(input logic [1:0] pressed);
    return (&pressed) ? 2'b11 : ~pressed;
  endfunction
endpackage

// File: rtl/debounce.sv
// debounce: 2-flop synchronizer, saturating hold counter, stable level and rise pulse for one raw bit
module debounce #(
  parameter int unsigned DEBOUNCE_BITS = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic stable_nxt_o,
  output logic rise_o
);
  logic [1:0] sync_q, sync_d;
  logic stable_q, stable_d;
  logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;
  logic diff, full;
  // Count consecutive cycles the synchronized level disagrees with the stable one; accept on the last count
  always_comb begin
    sync_d = {sync_q[0], raw_i};
    diff = sync_q[1] != stable_q;
    full = &cnt_q;
    stable_d = (diff && full) ? sync_q[1] : stable_q;
    cnt_d = (diff && !full) ? cnt_q + DEBOUNCE_BITS'(1) : '0;
  end
  // State registers; reset discards any partial count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      stable_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sync_q <= sync_d;
      stable_q <= stable_d;
      cnt_q <= cnt_d;
    end
  end
  assign stable_nxt_o = stable_d;
  assign rise_o = stable_d & ~stable_q;
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: debounces board buttons and console switches, applies SOCD, inversion and switch toggling
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_BITS = DEBOUNCE_BITS_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_BTN-1:0] btn_raw_i,
  input  logic [NUM_SW-1:0]  sw_raw_i,
  output logic [NUM_BTN-1:0] buttons_o,
  output logic [NUM_SW-1:0]  sw_o,
  output logic [NUM_BTN-1:0] press_o
);
  localparam int unsigned NUM_BITS = NUM_BTN + NUM_SW;
  logic [NUM_BITS-1:0] raw, stable_nxt, rise;
  logic [NUM_BTN-1:0] buttons_q, buttons_d, press_q, press_d;
  logic [NUM_SW-1:0] sw_q, sw_d;
  logic unused_sw_level;
  assign raw = {sw_raw_i, btn_raw_i};
  assign unused_sw_level = ^stable_nxt[NUM_BITS-1:NUM_BTN];
  genvar g;
  for (g = 0; g < NUM_BITS; g++) begin : g_db
    debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_db (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .raw_i       (raw[g]),
      .stable_nxt_o(stable_nxt[g]),
      .rise_o      (rise[g])
    );
  end
  // Next outputs from next stable levels so every output moves on the edge the stable level moves
  always_comb begin
    buttons_d = ~stable_nxt[NUM_BTN-1:0];
    buttons_d[BTN_DOWN:BTN_UP] = socd_pair(stable_nxt[BTN_DOWN:BTN_UP]);
    buttons_d[BTN_RIGHT:BTN_LEFT] = socd_pair(stable_nxt[BTN_RIGHT:BTN_LEFT]);
    press_d = rise[NUM_BTN-1:0];
    sw_d = sw_q ^ rise[NUM_BITS-1:NUM_BTN];
  end
  // Output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buttons_q <= '1;
      press_q <= '0;
      sw_q <= '0;
    end else begin
      buttons_q <= buttons_d;
      press_q <= press_d;
      sw_q <= sw_d;
    end
  end
  assign buttons_o = buttons_q;
  assign press_o = press_q;
  assign sw_o = sw_q;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: table vectors, hand sequences and randomized checks against a run-length model
module tb_input_conditioner;
  localparam int DB = 2;
  localparam int HOLD = 1 << DB;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] btn_raw = '0;
  logic [3:0] sw_raw = '0;
  logic [6:0] buttons, press;
  logic [3:0] sw;
  int total = 0;
  int bad = 0;

  input_conditioner #(.DEBOUNCE_BITS(DB)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .btn_raw_i(btn_raw),
    .sw_raw_i (sw_raw),
    .buttons_o(buttons),
    .sw_o     (sw),
    .press_o  (press)
  );

  always #5 clk = ~clk;

  // Reference: a level seen after a two-cycle delay is accepted once it has persisted HOLD consecutive edges
  int run[11];
  logic d1[11], d2[11], last[11];
  logic [10:0] lvl, mraw;
  logic s;
  logic [6:0] m_btn, m_press;
  logic [3:0] m_sw;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 11; k++) begin
        run[k] = 0; d1[k] = 0; d2[k] = 0; last[k] = 0;
      end
      lvl = '0; m_btn = 7'h7F; m_sw = '0; m_press = '0;
    end else begin
      mraw = {sw_raw, btn_raw};
      m_press = '0;
      for (int k = 0; k < 11; k++) begin
        s = d2[k];
        d2[k] = d1[k];
        d1[k] = mraw[k];
        run[k] = (s == last[k]) ? run[k] + 1 : 1;
        last[k] = s;
        if (s != lvl[k] && run[k] >= HOLD) begin
          if (s && k < 7) m_press[k] = 1'b1;
          if (s && k >= 7) m_sw[k-7] = ~m_sw[k-7];
          lvl[k] = s;
        end
      end
      m_btn = ~lvl[6:0];
      if (lvl[3] && lvl[4]) m_btn[4:3] = 2'b11;
      if (lvl[5] && lvl[6]) m_btn[6:5] = 2'b11;
    end
  end

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [6:0] btn;
    logic [3:0] sw;
    int hold;
    logic [6:0] e_btn;
    logic [3:0] e_sw;
    logic [6:0] e_press;
  } vec_t;
  vec_t vt[15];

  initial begin
    vt[0]  = '{7'h00, 4'h0, 3, 7'h7F, 4'h0, 7'h00};
    vt[1]  = '{7'h08, 4'h0, 8, 7'h77, 4'h0, 7'h00};
    vt[2]  = '{7'h18, 4'h0, 8, 7'h7F, 4'h0, 7'h00};
    vt[3]  = '{7'h08, 4'h0, 8, 7'h77, 4'h0, 7'h00};
    vt[4]  = '{7'h00, 4'h0, 8, 7'h7F, 4'h0, 7'h00};
    vt[5]  = '{7'h60, 4'h0, 8, 7'h7F, 4'h0, 7'h00};
    vt[6]  = '{7'h20, 4'h0, 8, 7'h5F, 4'h0, 7'h00};
    vt[7]  = '{7'h00, 4'h1, 8, 7'h7F, 4'h1, 7'h00};
    vt[8]  = '{7'h00, 4'h0, 8, 7'h7F, 4'h1, 7'h00};
    vt[9]  = '{7'h00, 4'h1, 8, 7'h7F, 4'h0, 7'h00};
    vt[10] = '{7'h00, 4'h0, 8, 7'h7F, 4'h0, 7'h00};
    vt[11] = '{7'h07, 4'hF, 8, 7'h78, 4'hF, 7'h00};
    vt[12] = '{7'h07, 4'h0, 5, 7'h78, 4'hF, 7'h00};
    vt[13] = '{7'h00, 4'h0, 8, 7'h7F, 4'hF, 7'h00};
    vt[14] = '{7'h02, 4'h0, 6, 7'h7D, 4'hF, 7'h02};

    repeat (2) @(negedge clk);
    check("reset buttons", buttons, 7'h7F);
    check("reset sw", {3'b0, sw}, 7'h00);
    check("reset press", press, 7'h00);

    // Clean press raised before edge 1: accepted at edge 6
    btn_raw = 7'h02;
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      check($sformatf("latency e%0d buttons", e), buttons, (e >= 6) ? 7'h7D : 7'h7F);
      check($sformatf("latency e%0d press", e), press, (e == 6) ? 7'h02 : 7'h00);
    end
    btn_raw = 7'h00;
    repeat (8) @(negedge clk);

    // Three-cycle glitch is rejected
    btn_raw = 7'h02;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      if (e == 3) btn_raw = 7'h00;
      check($sformatf("glitch3 e%0d buttons", e), buttons, 7'h7F);
      check($sformatf("glitch3 e%0d press", e), press, 7'h00);
    end

    // Four-cycle pulse is accepted
    btn_raw = 7'h02;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      if (e == 4) btn_raw = 7'h00;
      check($sformatf("pulse4 e%0d buttons", e), buttons, (e >= 6) ? 7'h7D : 7'h7F);
      check($sformatf("pulse4 e%0d press", e), press, (e == 6) ? 7'h02 : 7'h00);
    end
    repeat (8) @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      btn_raw = vt[i].btn;
      sw_raw = vt[i].sw;
      repeat (vt[i].hold) @(negedge clk);
      check($sformatf("row%0d buttons", i), buttons, vt[i].e_btn);
      check($sformatf("row%0d sw", i), {3'b0, sw}, {3'b0, vt[i].e_sw});
      check($sformatf("row%0d press", i), press, vt[i].e_press);
    end

    // Reset mid-count with all buttons held, then full latency after release
    btn_raw = 7'h7F;
    sw_raw = 4'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset buttons", buttons, 7'h7F);
    check("midreset sw", {3'b0, sw}, 7'h00);
    check("midreset press", press, 7'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      check($sformatf("postreset e%0d buttons", e), buttons, (e >= 6) ? 7'h78 : 7'h7F);
      check($sformatf("postreset e%0d press", e), press, (e == 6) ? 7'h7F : 7'h00);
    end

    // Randomized levels with a quiet window each 40 cycles and one reset pulse
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      check($sformatf("rand c%0d buttons", c), buttons, m_btn);
      check($sformatf("rand c%0d sw", c), {3'b0, sw}, {3'b0, m_sw});
      check($sformatf("rand c%0d press", c), press, m_press);
      rst_n = (c != 600);
      if ((c % 40) < 30) begin
        for (int k = 0; k < 7; k++) if ($urandom_range(0, 5) == 0) btn_raw[k] = ~btn_raw[k];
        for (int k = 0; k < 4; k++) if ($urandom_range(0, 5) == 0) sw_raw[k] = ~sw_raw[k];
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
